// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU. Each operation
// is granted in IDLE, executed in EXEC and held as a response in RESP
// until the consumer takes it.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority, where
// requester 0 always beats requester 1. Without it, arbitration is
// round-robin, tracked by a one-bit last_grant register.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Requester inputs gathered into arrays so the winner can be selected by index.
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];
    logic [2:0]       req_op [2];

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // The latched operation and the response registers.
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [2:0]       op_reg;
    logic             id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_id_reg;

    logic       grant_id;
    logic       grant_any;
    logic [1:0] grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = req_valid[0] ? 1'b0 : 1'b1;
    end
`else
    logic last_grant_reg;

    // Round-robin: on a tie, the requester that was not granted last time wins.
    // A lone requester always wins.
    always_comb begin
        if (&req_valid) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = req_valid[0] ? 1'b0 : 1'b1;
        end
    end

    // Remember the most recent winner. Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (grant_any) begin
            last_grant_reg <= grant_id;
        end
    end
`endif

    // Grants are only given in IDLE, and never while reset is held.
    assign grant_any = (|req_valid) && (state_reg == IDLE) && !reset;

    // Decode the one-hot ready pulse, so at most one requester sees ready.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // State register. Reset abandons any operation that is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: one grant, one execute cycle, then hold until the consumer accepts.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's operation at grant time. Capture the ALU output at the end of EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= 3'b000;
            id_reg         <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else begin
            if (grant_any) begin
                a_reg  <= req_a[grant_id];
                b_reg  <= req_b[grant_id];
                op_reg <= req_op[grant_id];
                id_reg <= grant_id;
            end
            if (state_reg == EXEC) begin
                rsp_result_reg <= alu_result;
                rsp_zero_reg   <= alu_zero;
                rsp_id_reg     <= id_reg;
            end
        end
    end

    // The operands always come from the latch. The function select is parked
    // at add (000) outside EXEC. Unused encodings pass through untouched.
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign alu_control = (state_reg == EXEC) ? op_reg : 3'b000;

    assign rsp_valid  = (state_reg == RESP);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. It provides a behavioural model of
// the shared ALU. Expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_control;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [W-1:0] rsp_result;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the shared ALU.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse reset for one cycle. The task starts and ends 1 time unit after a rising edge.
    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Run one complete transaction with rsp_ready held high.
    // The task starts in IDLE, 1 time unit after a rising edge, and ends the same way.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                          input bit exp_id, input logic [W-1:0] exp_res, input bit exp_zero,
                          input string tag);
        logic [2:0]   exp_op;
        logic [W-1:0] exp_a;
        exp_op = exp_id ? op1 : op0;
        exp_a  = exp_id ? a1 : a0;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = 1'b1;
        #2;
        check({tag, ".ready0"}, 32'(req0_ready), 32'(exp_id == 1'b0));
        check({tag, ".ready1"}, 32'(req1_ready), 32'(exp_id == 1'b1));
        @(posedge clk); #1;
        check({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".exec_ctrl"}, 32'(alu_control), 32'(exp_op));
        check({tag, ".exec_a"}, 32'(alu_a), 32'(exp_a));
        @(posedge clk); #1;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, ".rsp_result"}, 32'(rsp_result), 32'(exp_res));
        check({tag, ".rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
        check({tag, ".rsp_ctrl"}, 32'(alu_control), 32'd0);
        check({tag, ".rsp_ready0"}, 32'(req0_ready), 32'd0);
        check({tag, ".rsp_ready1"}, 32'(req1_ready), 32'd0);
        $display("txn %s: id=%0d result=%0h zero=%0d", tag, rsp_id, rsp_result, rsp_zero);
        @(posedge clk); #1;
    endtask

    bit fixed_prio;
    bit exp_first;

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;

        // Reset state: readies stay low even with both requesters valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready0", 32'(req0_ready), 32'd0);
        check("rst.ready1", 32'(req1_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_id", 32'(rsp_id), 32'd0);
        check("rst.rsp_result", 32'(rsp_result), 32'd0);
        check("rst.rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst.alu_ctrl", 32'(alu_control), 32'd0);
        check("rst.alu_a", 32'(alu_a), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;

        // Only requester 0 is valid: 5 + 3.
        do_txn(1, 0, 16'd5, 16'd3, 3'b000, 16'd0, 16'd0, 3'b000, 1'b0, 16'd8, 1'b0, "add0");

        // Both requesters valid continuously, starting from reset.
        pulse_reset();
        do_txn(1, 1, 16'd1, 16'd1, 3'b000, 16'd2, 16'd2, 3'b000, 1'b0, 16'd2, 1'b0, "both_a");
        do_txn(1, 1, 16'd1, 16'd1, 3'b000, 16'd2, 16'd2, 3'b000,
               fixed_prio ? 1'b0 : 1'b1, fixed_prio ? 16'd2 : 16'd4, 1'b0, "both_b");
        do_txn(1, 1, 16'd1, 16'd1, 3'b000, 16'd2, 16'd2, 3'b000, 1'b0, 16'd2, 1'b0, "both_c");
        do_txn(1, 1, 16'd1, 16'd1, 3'b000, 16'd2, 16'd2, 3'b000,
               fixed_prio ? 1'b0 : 1'b1, fixed_prio ? 16'd2 : 16'd4, 1'b0, "both_d");

        // A lone requester 1 wins twice in a row. Also covers sub-to-zero, slt, and, or,
        // and an unused encoding passing through.
        do_txn(0, 1, 16'd0, 16'd0, 3'b000, 16'd7, 16'd7, 3'b001, 1'b1, 16'd0, 1'b1, "sub1");
        do_txn(0, 1, 16'd0, 16'd0, 3'b000, 16'd2, 16'd9, 3'b100, 1'b1, 16'd1, 1'b0, "slt1");
        do_txn(1, 0, 16'h00F0, 16'h0FF0, 3'b010, 16'd0, 16'd0, 3'b000, 1'b0, 16'h00F0, 1'b0, "and0");
        do_txn(0, 1, 16'd0, 16'd0, 3'b000, 16'h1200, 16'h0034, 3'b011, 1'b1, 16'h1234, 1'b0, "or1");
        do_txn(1, 0, 16'd3, 16'd4, 3'b101, 16'd0, 16'd0, 3'b000, 1'b0, 16'd0, 1'b1, "op5");

        // Backpressure: rsp_ready stays low for 4 cycles while in RESP.
        req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0001; req0_op = 3'b001;
        req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        check("bp.grant", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp.rsp_result", 32'(rsp_result), 32'h000F);
            check("bp.ready0", 32'(req0_ready), 32'd0);
            check("bp.ready1", 32'(req1_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.accept_ready0", 32'(req0_ready), 32'd0);
        check("bp.accept_ready1", 32'(req1_ready), 32'd0);
        check("bp.accept_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        check("bp.idle_valid", 32'(rsp_valid), 32'd0);
        check("bp.idle_ready1", 32'(req1_ready), fixed_prio ? 32'd0 : 32'd1);
        $display("txn backpressure: result=%0h", rsp_result);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Assert reset asynchronously in the middle of EXEC.
        req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd4; req0_op = 3'b001;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b1;
        check("ar.exec_ctrl", 32'(alu_control), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("ar.rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar.alu_ctrl", 32'(alu_control), 32'd0);
        check("ar.alu_a", 32'(alu_a), 32'd0);
        check("ar.ready0", 32'(req0_ready), 32'd0);
        check("ar.ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("ar.no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        $display("txn async_reset: operation discarded");
        do_txn(1, 1, 16'd6, 16'd1, 3'b001, 16'd0, 16'd0, 3'b000, 1'b0, 16'd5, 1'b0, "post_rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width; WIDTH must match the shared ALU.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands for each requester.
REQ-007 req0_op / req1_op  in  3  ALU function select: 000 add, 001 sub, 010 and, 011 or, 100 set-less-than.
REQ-008 alu_a, alu_b  out  WIDTH  operands driven to the shared ALU.
REQ-009 alu_control  out  3  function select driven to the shared ALU.
REQ-010 alu_result  in  WIDTH  combinational ALU result.
REQ-011 alu_zero  in  1  ALU zero flag.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rsp_id  out  1  index of the requester that owns the response.
REQ-015 rsp_result  out  WIDTH  registered ALU result.
REQ-016 rsp_zero  out  1  registered zero flag.

Function
REQ-017 The FSM shall have three states: IDLE, EXEC and RESP; reset state is IDLE.
REQ-018 In IDLE, when at least one reqN_valid is high, the block shall:
- pick a winner per REQ-022 or REQ-030;
- assert that winner's reqN_ready combinationally in the same cycle;
- latch its a, b, op and id;
- move to EXEC.
REQ-019 reqN_ready shall be low in EXEC and RESP, and low for the loser; exactly one ready at most per cycle.
REQ-020 In EXEC, alu_a, alu_b and alu_control shall come from the latched registers. At the next edge the block shall capture alu_result and alu_zero into rsp_result and rsp_zero, then move to RESP.
REQ-021 In RESP:
- rsp_valid shall be high, and rsp_id, rsp_result and rsp_zero shall be held stable until rsp_ready is sampled high;
- on that edge the block shall return to IDLE;
- no new request is accepted in the same cycle;
- minimum occupancy is 3 cycles per operation.
REQ-022 Default arbitration is round-robin with a 1-bit last_grant register (reset 1, so requester 0 wins first). When both are valid, the requester that is not last_grant wins. last_grant shall update on every grant.
REQ-023 A single valid requester shall always win, whatever last_grant holds.
REQ-024 Outside EXEC, alu_a and alu_b shall drive the latched values and alu_control shall drive 000; unused encodings 101-111 pass through unchanged.
REQ-025 A requester dropping valid in the same cycle as a grant is a protocol violation; the behaviour is not required.

Reset
REQ-026 On assertion of reset, regardless of clk, the block shall:
- return to IDLE;
- force rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0;
- clear the latched operands and op to 0;
- set last_grant=1.
REQ-027 Reset during EXEC or RESP shall discard the in-flight operation; no response is produced for it.
REQ-028 Readies shall be 0 while reset is high.

Configuration
REQ-029 The macro ALU_ARB_FIXED_PRIO_EN selects the arbitration policy.
REQ-030 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 shall always win over requester 1, and last_grant is not implemented. Without it, round-robin per REQ-022 applies.

Verification
REQ-031 Only req0 valid (a=5, b=3, op=000), rsp_ready=1 -> req0_ready in the first cycle; rsp_valid two cycles later with rsp_id=0, rsp_result=8, rsp_zero=0.
REQ-032 Both valid continuously, rsp_ready=1 (round-robin build) -> grants alternate 0,1,0,1; fixed-priority build -> grants 0,0,0,0.
REQ-033 req1 a=7, b=7, op=001 -> rsp_result=0, rsp_zero=1; op=100 with a=2, b=9 -> rsp_result=1.
REQ-034 rsp_ready held low for 4 cycles in RESP -> rsp_valid and rsp_result stable throughout, both readies 0; IDLE after rsp_ready=1.
REQ-035 Reset asserted mid-EXEC, asynchronously to clk -> rsp_valid=0 and FSM in IDLE immediately; the next grant goes to req0.
